// File: rtl/inst_queue_pkg.sv
// Shared widths and tail-pointer write-enable decoders for the
// fetch-to-decode instruction queue.
package inst_queue_pkg;

   localparam int FS_TO_IQ_BUS_WD = 64;
   localparam int IQ_TO_DS_BUS_WD = 64;
   localparam int IQ_DEPTH        = 4;
   localparam int IQ_PTR_W        = 2;

   function automatic logic [3:0] decoder_2_4(input logic [1:0] sel);
      logic [3:0] y;
      y = '0;
      unique case (sel)
         2'd0: y[0] = 1'b1;
         2'd1: y[1] = 1'b1;
         2'd2: y[2] = 1'b1;
         2'd3: y[3] = 1'b1;
      endcase
      return y;
   endfunction

   function automatic logic [15:0] decoder_4_16(input logic [3:0] sel);
      logic [15:0] y;
      y = '0;
      y[sel] = 1'b1;
      return y;
   endfunction

endpackage

// File: rtl/inst_queue_ptr.sv
// Wrapping pointer register for the instruction queue; instantiated
// once for the head and once for the tail.
module iq_ptr
   import inst_queue_pkg::*;
#(
   parameter int W = IQ_PTR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer with a
// zero-latency head read and no fetch-to-decode bypass.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = IQ_PTR_W,
   parameter int BUS_W = FS_TO_IQ_BUS_WD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             fs_to_iq_valid,
   input  logic [BUS_W-1:0] fs_to_iq_bus,
   output logic             iq_allowin,
   output logic             iq_to_ds_valid,
   output logic [BUS_W-1:0] iq_to_ds_bus,
   input  logic             ds_allowin,
   output logic [PTR_W:0]   iq_count
);

   logic [BUS_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W:0]   count;
   logic [DEPTH-1:0] wen;
   logic             push;
   logic             pop;

   assign iq_allowin     = (count != (PTR_W+1)'(DEPTH));
   assign iq_to_ds_valid = (count != '0);
   assign iq_to_ds_bus   = mem[head_ptr];
   assign iq_count       = count;

   assign push = fs_to_iq_valid & iq_allowin & ~flush;
   assign pop  = iq_to_ds_valid & ds_allowin & ~flush;

   if (DEPTH == 4) begin : g_dec4
      assign wen = decoder_2_4(2'(tail_ptr));
   end else if (DEPTH == 16) begin : g_dec16
      assign wen = decoder_4_16(4'(tail_ptr));
   end else begin : g_decn
      for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
         assign wen[i] = (tail_ptr == PTR_W'(i));
      end
   end

   iq_ptr #(.W(PTR_W)) u_head (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (pop),
      .ptr   (head_ptr)
   );

   iq_ptr #(.W(PTR_W)) u_tail (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (push),
      .ptr   (tail_ptr)
   );

   // storage is deliberately not reset; count hides stale entries
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && wen[i]) begin
            mem[i] <= fs_to_iq_bus;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count <= count - (PTR_W+1)'(1);
      end
   end

`ifndef SYNTHESIS
   logic             prev_hold;
   logic [BUS_W-1:0] prev_bus;

   always_ff @(posedge clk) begin
      prev_hold <= fs_to_iq_valid & ~iq_allowin & ~flush & ~reset;
      prev_bus  <= fs_to_iq_bus;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (count <= (PTR_W+1)'(DEPTH))
            else $error("iq count overflow %0d", count);
         if (prev_hold && fs_to_iq_valid && !flush) begin
            assert (fs_to_iq_bus == prev_bus)
               else $error("fetch bus changed while stalled");
         end
      end
   end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam int BUS_W = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             fs_to_iq_valid;
   logic [BUS_W-1:0] fs_to_iq_bus;
   logic             iq_allowin;
   logic             iq_to_ds_valid;
   logic [BUS_W-1:0] iq_to_ds_bus;
   logic             ds_allowin;
   logic [PTR_W:0]   iq_count;

   always #5 clk = ~clk;

   inst_queue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .BUS_W (BUS_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .fs_to_iq_valid (fs_to_iq_valid),
      .fs_to_iq_bus   (fs_to_iq_bus),
      .iq_allowin     (iq_allowin),
      .iq_to_ds_valid (iq_to_ds_valid),
      .iq_to_ds_bus   (iq_to_ds_bus),
      .ds_allowin     (ds_allowin),
      .iq_count       (iq_count)
   );

   logic [BUS_W-1:0] q[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmp_model();
      check_eq("valid", 64'(iq_to_ds_valid), 64'(q.size() != 0));
      check_eq("allowin", 64'(iq_allowin), 64'(q.size() != DEPTH));
      check_eq("count", 64'(iq_count), 64'(q.size()));
      if (q.size() != 0) check_eq("head_bus", iq_to_ds_bus, q[0]);
   endtask

   task automatic cycle(input logic v, input logic [63:0] b,
                        input logic dsa, input logic fl, input logic rst);
      logic mpush, mpop;
      fs_to_iq_valid = v;
      fs_to_iq_bus   = b;
      ds_allowin     = dsa;
      flush          = fl;
      reset          = rst;
      mpush = v && (q.size() != DEPTH) && !fl;
      mpop  = (q.size() != 0) && dsa && !fl;
      @(posedge clk);
      if (rst || fl) begin
         q.delete();
      end else begin
         if (mpop) void'(q.pop_front());
         if (mpush) q.push_back(b);
      end
      @(negedge clk);
      cmp_model();
   endtask

   function automatic logic [63:0] ent(input int i);
      logic [31:0] pc;
      logic [31:0] ins;
      pc  = 32'h1c00_0000 + 32'(4 * i);
      ins = 32'h0280_0c04 + 32'(i);
      return {pc, ins};
   endfunction

   initial begin
      logic [63:0] b;
      logic        v, dsa, fl, rst, held;
      reset = 1'b1;
      flush = 1'b0;
      fs_to_iq_valid = 1'b0;
      fs_to_iq_bus = '0;
      ds_allowin = 1'b0;
      @(negedge clk);

      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check_eq("rst_valid", 64'(iq_to_ds_valid), 64'd0);
      check_eq("rst_allowin", 64'(iq_allowin), 64'd1);
      check_eq("rst_count", 64'(iq_count), 64'd0);

      for (int i = 0; i < 4; i++) cycle(1, ent(i), 0, 0, 0);
      check_eq("fill_count", 64'(iq_count), 64'd4);
      check_eq("fill_allowin", 64'(iq_allowin), 64'd0);
      cycle(1, ent(4), 0, 0, 0);
      cycle(1, ent(4), 0, 0, 0);
      check_eq("held_count", 64'(iq_count), 64'd4);

      for (int i = 0; i < 4; i++) begin
         check_eq("drain_pc", 64'(iq_to_ds_bus[63:32]),
                  64'(32'h1c00_0000 + 32'(4 * i)));
         cycle(0, 0, 1, 0, 0);
      end
      check_eq("drain_valid", 64'(iq_to_ds_valid), 64'd0);
      check_eq("drain_count", 64'(iq_count), 64'd0);

      cycle(1, ent(10), 0, 0, 0);
      cycle(1, ent(11), 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(1, ent(12 + i), 1, 0, 0);
         check_eq("pp_count", 64'(iq_count), 64'd2);
      end

      cycle(1, ent(30), 0, 0, 0);
      check_eq("pre_flush_count", 64'(iq_count), 64'd3);
      cycle(1, ent(31), 0, 1, 0);
      check_eq("flush_valid", 64'(iq_to_ds_valid), 64'd0);
      check_eq("flush_count", 64'(iq_count), 64'd0);

      for (int i = 0; i < 4; i++) cycle(1, ent(40 + i), 0, 0, 0);
      check_eq("fp_allowin_full", 64'(iq_allowin), 64'd0);
      cycle(1, ent(44), 1, 0, 0);
      check_eq("fp_count", 64'(iq_count), 64'd3);
      check_eq("fp_allowin", 64'(iq_allowin), 64'd1);
      cycle(1, ent(44), 0, 0, 0);
      check_eq("fp_accept", 64'(iq_count), 64'd4);

      held = 1'b0;
      b = '0;
      for (int n = 0; n < 600; n++) begin
         v   = ($urandom % 4) != 0;
         if (!(held && v)) b = {$urandom, $urandom};
         dsa = ($urandom % 3) != 0;
         fl  = ($urandom % 20) == 0;
         rst = ($urandom % 60) == 0;
         held = v && (q.size() == DEPTH) && !fl && !rst;
         cycle(v, b, dsa, fl, rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
